mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle sequencer for the mips datapath: one FSM drives the PC, IR, register_block,
//  alu/alu_control, memory_block and mux selects. Instructions are split into FETCH/DECODE/
//  EXEC/MEM/WB steps. Variable-latency memory is handled through a mem_ready handshake.
//  Outputs are Moore-style, decoded from the state register; sits beside control_unit in mips.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting for mem_ready before trapping (>=1)
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clock        in   1      system clock, rising edge
//  reset        in   1      synchronous, active-high
//  opcode       in   6      IR[31:26] (IR as latched via ir_write)
//  funct        in   6      IR[5:0]
//  zero         in   1      alu zero flag, valid in BRANCH state
//  mem_ready    in   1      memory_block access complete this cycle
//  pc_write     out  1      load PC this cycle
//  pc_src       out  2      00 PC+4, 01 branch target, 10 jump target
//  ir_write     out  1      latch instruction into IR
//  mem_read     out  1      memory read request
//  mem_write    out  1      memory write request
//  iord         out  1      0 address=PC, 1 address=ALUOut
//  reg_write    out  1      register_block write enable
//  reg_dst      out  1      0 rt, 1 rd
//  mem_to_reg   out  1      0 ALUOut, 1 MDR
//  alu_src_a    out  1      0 PC, 1 rs
//  alu_src_b    out  2      00 rt, 01 const 4, 10 sign_ext_imm, 11 sign_ext_imm<<2
//  alu_op       out  3      000 add, 001 sub, 010 decode funct (to alu_control)
//  trap         out  1      sticky: illegal opcode or memory timeout
//  retired      out  CNT_W  count of completed instructions
// BEHAVIOUR
//  - States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_MEM, BRANCH,
//    JUMP, TRAP. After reset: state=FETCH, trap=0, retired=0, wait counter=0.
//    Every output is defined by the current state only (BRANCH pc_write also uses zero).
//  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000. Holds until mem_ready.
//    In the mem_ready cycle: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (precompute branch target). Next state:
//    opcode 0x00->EXEC_R, 0x23/0x2B->MEM_ADDR, 0x04->BRANCH, 0x08->EXEC_I, 0x02->JUMP,
//    any other->TRAP.
//  - EXEC_R: src_a=1, src_b=00, alu_op=010 -> WB_R. WB_R: reg_write=1, reg_dst=1,
//    mem_to_reg=0; retired++ -> FETCH.
//  - EXEC_I (addi): src_a=1, src_b=10, alu_op=000. Writes back with reg_dst=0 and
//    reg_write=1 in the same cycle: ALUOut path is combinational. retired++ -> FETCH.
//  - MEM_ADDR: src_a=1, src_b=10, alu_op=000. Next: lw->MEM_RD, sw->MEM_WR.
//  - MEM_RD: mem_read=1, iord=1; on mem_ready -> WB_MEM. WB_MEM: reg_write=1, reg_dst=0,
//    mem_to_reg=1; retired++ -> FETCH.
//  - MEM_WR: mem_write=1, iord=1; on mem_ready: retired++ -> FETCH.
//  - BRANCH: src_a=1, src_b=00, alu_op=001, pc_src=01, pc_write=zero; retired++ -> FETCH.
//  - JUMP: pc_write=1, pc_src=10; retired++ -> FETCH.
//  - Latency with zero-wait memory (mem_ready=1 on first request cycle): R 4, addi 3, lw 5,
//    sw 4, beq 3, j 3 cycles. Each memory wait cycle adds 1.
//  - Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR; increments each cycle there
//    with mem_ready=0. Reaching MEM_TIMEOUT with mem_ready still 0 -> TRAP.
//    A mem_ready arriving in the same cycle the count hits the limit wins: no trap.
//  - TRAP: all enables 0, trap=1, stays until reset. retired is frozen.
//  - Request outputs: mem_read/mem_write stay high and stable until mem_ready is sampled.
//    Never both high. pc_write and reg_write never high in the same cycle.
//  - retired wraps modulo 2^CNT_W.
//  - Reset mid-operation (any state, any wait): the next state is FETCH, all enables drop
//    to 0 in the reset cycle, trap=0, retired=0.
// TESTING
//  1. reset, mem_ready=1, IR=add (op 0x00 funct 0x20) -> states F,D,EXEC_R,WB_R;
//     reg_write=1, reg_dst=1 on cycle 4; retired=1.
//  2. lw (0x23) with mem_ready low 3 cycles in MEM_RD -> mem_read,iord held high 4 cycles;
//     WB_MEM mem_to_reg=1; total 8 cycles.
//  3. beq (0x04): zero=1 -> pc_write=1, pc_src=01 in cycle 3; repeat zero=0 -> pc_write=0.
//  4. opcode 0x3F -> TRAP after DECODE; trap=1, all enables 0 for 20+ cycles;
//     reset -> FETCH, trap=0.
//  5. MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 4 cycles;
//     mem_ready=1 exactly at cycle 4 -> DECODE, no trap.
//  6. CNT_W=3, 9 j instructions -> retired=1; assert reset during MEM_WR -> FETCH,
//     mem_write=0 next cycle.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle sequencer for the mips datapath. A single Moore FSM steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB and drives the PC, IR,
// register file, ALU and memory selects. Memory steps wait on mem_ready and
// trap if the wait runs too long. It also counts retired instructions.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  // The wait counter only has to hold MEM_TIMEOUT-1. It traps or leaves the
  // state at that value.
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_inc;
  logic              retire;
  logic              at_limit;

  // funct is consumed by alu_control, not by the sequencer.
  logic unused_funct;
  assign unused_funct = ^funct;

  assign at_limit = (wait_cnt == WAIT_LIMIT);

  // State, wait counter and retired counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (wait_inc)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (retire)
        retired <= retired + CNT_W'(1);
    end
  end

  // Next-state selection and state-decoded control outputs.
  always_comb begin
    state_next = state;
    wait_inc   = 1'b0;
    retire     = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    trap       = (state == S_TRAP);
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (at_limit) begin
          state_next = S_TRAP;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          6'h00:        state_next = S_EXEC_R;
          6'h23, 6'h2B: state_next = S_MEM_ADDR;
          6'h04:        state_next = S_BRANCH;
          6'h08:        state_next = S_EXEC_I;
          6'h02:        state_next = S_JUMP;
          default:      state_next = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b010;
        state_next = S_WB_R;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_EXEC_I: begin
        // addi result goes straight from the ALU to the register file.
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready)
          state_next = S_WB_MEM;
        else if (at_limit)
          state_next = S_TRAP;
        else
          wait_inc = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (at_limit) begin
          state_next = S_TRAP;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b001;
        pc_src     = 2'b01;
        pc_write   = zero;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
    // A reset cycle must not issue any request or write.
    if (reset) begin
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: an instruction-step model predicts every
// control output each cycle, plus literal spot checks from hand-worked traces.
module tb_mips_multicycle_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [5:0]    opcode, funct;
  logic          zero, mem_ready;
  logic          pc_write, ir_write, mem_read, mem_write, iord;
  logic          reg_write, reg_dst, mem_to_reg, alu_src_a, trap;
  logic [1:0]    pc_src, alu_src_b;
  logic [2:0]    alu_op;
  logic [CW-1:0] retired;
  logic [16:0]   dut_out;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .trap(trap), .retired(retired)
  );

  always #5 clock = ~clock;

  assign dut_out = {pc_write, pc_src, ir_write, mem_read, mem_write, iord,
                    reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                    alu_op, trap};

  // Step kinds and instruction classes of the model.
  localparam int K_F = 0, K_D = 1, K_EXR = 2, K_WBR = 3, K_EXI = 4, K_MA = 5;
  localparam int K_MRD = 6, K_MWR = 7, K_WBM = 8, K_BR = 9, K_JMP = 10, K_END = 11;
  localparam int C_NONE = 0, C_R = 1, C_I = 2, C_LW = 3, C_SW = 4;
  localparam int C_BEQ = 5, C_J = 6, C_ILL = 7;

  int n_cmp = 0;
  int n_bad = 0;
  int m_step, m_cls, m_wait, m_ret;
  logic m_trapped;

  function automatic int kind_of(int cls, int step);
    if (step == 0) return K_F;
    if (step == 1) return K_D;
    case (cls)
      C_R:   if (step == 2) return K_EXR; else if (step == 3) return K_WBR;
      C_I:   if (step == 2) return K_EXI;
      C_LW:  if (step == 2) return K_MA; else if (step == 3) return K_MRD;
             else if (step == 4) return K_WBM;
      C_SW:  if (step == 2) return K_MA; else if (step == 3) return K_MWR;
      C_BEQ: if (step == 2) return K_BR;
      C_J:   if (step == 2) return K_JMP;
      default: ;
    endcase
    return K_END;
  endfunction

  function automatic int cls_of(logic [5:0] op);
    case (op)
      6'h00: return C_R;
      6'h08: return C_I;
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h04: return C_BEQ;
      6'h02: return C_J;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [16:0] expect_out(int k, logic rdy, logic z,
                                             logic trapped, logic rst);
    logic pw, irw, mr, mw, io, rw, rd, m2r, sa, trp;
    logic [1:0] ps, sb;
    logic [2:0] op;
    {pw, irw, mr, mw, io, rw, rd, m2r, sa, trp} = '0;
    ps = 2'b00; sb = 2'b00; op = 3'b000;
    if (rst) trp = trapped;
    else if (trapped) trp = 1'b1;
    else begin
      case (k)
        K_F:   begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
        K_D:   sb = 2'b11;
        K_EXR: begin sa = 1; op = 3'b010; end
        K_WBR: begin rw = 1; rd = 1; end
        K_EXI: begin sa = 1; sb = 2'b10; rw = 1; end
        K_MA:  begin sa = 1; sb = 2'b10; end
        K_MRD: begin mr = 1; io = 1; end
        K_MWR: begin mw = 1; io = 1; end
        K_WBM: begin rw = 1; m2r = 1; end
        K_BR:  begin sa = 1; op = 3'b001; ps = 2'b01; pw = z; end
        K_JMP: begin pw = 1; ps = 2'b10; end
        default: ;
      endcase
    end
    return {pw, ps, irw, mr, mw, io, rw, rd, m2r, sa, sb, op, trp};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs for one cycle and compare all outputs to the model mid-cycle.
  task automatic half(input logic rdy, input logic z, input logic rst);
    mem_ready = rdy;
    zero      = z;
    reset     = rst;
    @(negedge clock);
    chk("outputs", 32'(dut_out),
        32'(expect_out(kind_of(m_cls, m_step), rdy, z, m_trapped, rst)));
    chk("retired", 32'(retired), 32'(m_ret % (1 << CW)));
  endtask

  // Clock edge: advance the model with the inputs the DUT just sampled.
  task automatic tick();
    int k;
    @(posedge clock);
    if (reset) begin
      m_step = 0; m_cls = C_NONE; m_wait = 0; m_trapped = 1'b0; m_ret = 0;
    end else if (!m_trapped) begin
      k = kind_of(m_cls, m_step);
      if ((k == K_F || k == K_MRD || k == K_MWR) && !mem_ready) begin
        if (m_wait + 1 >= TMO) m_trapped = 1'b1;
        else m_wait++;
      end else begin
        m_wait = 0;
        if (k == K_D) begin
          m_cls = cls_of(opcode);
          if (m_cls == C_ILL) m_trapped = 1'b1;
          else m_step = 2;
        end else if (kind_of(m_cls, m_step + 1) == K_END) begin
          m_ret++;
          m_step = 0;
          m_cls = C_NONE;
        end else begin
          m_step++;
        end
      end
    end
    #1;
  endtask

  task automatic cyc(input logic rdy, input logic z, input logic rst);
    half(rdy, z, rst);
    tick();
  endtask

  initial begin
    opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0; reset = 1'b1;
    m_step = 0; m_cls = C_NONE; m_wait = 0; m_trapped = 1'b0; m_ret = 0;
    tick();

    // add: F D EXEC_R WB_R
    opcode = 6'h00; funct = 6'h20;
    half(1, 0, 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_trap", 32'(trap), 0);
    chk("f_ir_write", 32'(ir_write), 1);
    chk("f_pc_write", 32'(pc_write), 1);
    tick();
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    half(1, 0, 0);
    chk("add_reg_write", 32'(reg_write), 1);
    chk("add_reg_dst", 32'(reg_dst), 1);
    tick();

    // lw with three wait cycles in MEM_RD: 8 cycles total
    opcode = 6'h23;
    half(1, 0, 0);
    chk("add_retired", 32'(retired), 1);
    tick();
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      half((i == 3) ? 1'b1 : 1'b0, 0, 0);
      chk("lw_mem_read", 32'(mem_read), 1);
      chk("lw_iord", 32'(iord), 1);
      tick();
    end
    half(1, 0, 0);
    chk("lw_mem_to_reg", 32'(mem_to_reg), 1);
    tick();

    // beq taken then not taken
    opcode = 6'h04;
    half(1, 0, 0);
    chk("lw_retired", 32'(retired), 2);
    tick();
    cyc(1, 0, 0);
    half(1, 1, 0);
    chk("beq_pc_write", 32'(pc_write), 1);
    chk("beq_pc_src", 32'(pc_src), 1);
    tick();
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    half(1, 0, 0);
    chk("beq_nt_pc_write", 32'(pc_write), 0);
    tick();

    // addi, sw with one wait, j
    opcode = 6'h08;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    opcode = 6'h2B;
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(0, 0, 0); cyc(1, 0, 0);
    opcode = 6'h02;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);

    // fetch: ready arrives on the 4th cycle -> no trap
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    half(1, 0, 0);
    chk("late_ready_trap", 32'(trap), 0);
    chk("late_ready_retired", 32'(retired), 7);
    tick();
    cyc(1, 0, 0);
    // fetch: ready stuck low -> trap after 4 cycles
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    half(1, 0, 0);
    chk("tmo_trap", 32'(trap), 1);
    tick();
    for (int i = 0; i < 20; i++) cyc(i[0], i[1], 0);
    cyc(1, 0, 1);
    half(1, 0, 0);
    chk("tmo_rst_trap", 32'(trap), 0);
    chk("tmo_rst_retired", 32'(retired), 0);
    tick();

    // illegal opcode traps after decode
    opcode = 6'h3F;
    cyc(1, 0, 0);
    for (int i = 0; i < 22; i++) begin
      half(1, 1, 0);
      if (i == 0) begin
        chk("ill_trap", 32'(trap), 1);
        chk("ill_enables", 32'({pc_write, ir_write, mem_read, mem_write, reg_write}), 0);
      end
      tick();
    end
    cyc(1, 0, 1);
    half(0, 0, 0);
    chk("ill_rst_trap", 32'(trap), 0);
    chk("ill_rst_fetch", 32'(mem_read), 1);
    tick();

    // lw timing out in MEM_RD
    cyc(1, 0, 1);
    opcode = 6'h23;
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    half(1, 0, 0);
    chk("mrd_tmo_trap", 32'(trap), 1);
    tick();
    cyc(1, 0, 1);

    // nine jumps wrap a 3-bit counter to 1
    opcode = 6'h02;
    for (int i = 0; i < 27; i++) cyc(1, 0, 0);
    opcode = 6'h2B;
    half(1, 0, 0);
    chk("wrap_retired", 32'(retired), 1);
    tick();
    cyc(1, 0, 0); cyc(1, 0, 0);
    half(0, 0, 0);
    chk("sw_mem_write", 32'(mem_write), 1);
    tick();
    half(0, 0, 1);
    chk("sw_rst_mem_write", 32'(mem_write), 0);
    tick();
    half(0, 0, 0);
    chk("post_rst_mem_write", 32'(mem_write), 0);
    chk("post_rst_fetch", 32'(mem_read), 1);
    chk("post_rst_retired", 32'(retired), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
